// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and helpers for the RAM arbiter
package mem_arbiter_pkg;

    localparam int RAM_ADDR_W = 17;

    localparam logic [2:0] MA_LEN_B = 3'd1;
    localparam logic [2:0] MA_LEN_H = 3'd2;
    localparam logic [2:0] MA_LEN_W = 3'd4;

    typedef enum logic [2:0] {
        MA_IDLE,
        MA_IF_RD,
        MA_LD_RD,
        MA_ST_WR,
        MA_DONE
    } ma_state_t;

    typedef enum logic [1:0] {
        ACC_IF,
        ACC_LD,
        ACC_ST
    } acc_kind_t;

    // Anything other than byte or half is serviced as a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            MA_LEN_B: return MA_LEN_B;
            MA_LEN_H: return MA_LEN_H;
            default:  return MA_LEN_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] len, input logic [1:0] a);
        return ((len == MA_LEN_H) && a[0]) || ((len == MA_LEN_W) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_byte_packer.sv
// rtl/mem_byte_packer.sv - sign/zero extension of an assembled little-endian load
module mem_byte_packer
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] buffer_i,
    input  logic [2:0]  len_i,
    input  logic        signed_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = buffer_i;
        case (len_i)
            MA_LEN_B: word_o = {{24{signed_i & buffer_i[7]}}, buffer_i[7:0]};
            MA_LEN_H: word_o = {{16{signed_i & buffer_i[15]}}, buffer_i[15:0]};
            default:  word_o = buffer_i;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM arbiter for fetch and load/store; MEM_MISALIGN_TRAP_EN adds mem_misalign
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_load,
    input  logic              mem_save,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [2:0]        mem_len,
    input  logic              mem_signed,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              mem_misalign,
`endif
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    ma_state_t          state_q, state_d;
    acc_kind_t          kind_q, kind_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [2:0]         len_q, len_d;
    logic               sgn_q, sgn_d;
    logic [31:0]        buffer_q, buffer_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic               mis_q, mis_d;
`endif

    logic [2:0]  rd_off;
    logic [1:0]  cap_idx;
    logic [31:0] packed_word;

    wire unused_addr_hi = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    mem_byte_packer u_packer (
        .buffer_i (buffer_q),
        .len_i    (len_q),
        .signed_i (sgn_q),
        .word_o   (packed_word)
    );

    // While frozen, keep re-reading the byte still awaiting capture so that
    // ram_din holds it when rdy returns.
    always_comb begin
        rd_off = 3'd0;
        if (cnt_q != 3'd0) begin
            rd_off = (rdy && (cnt_q != len_q)) ? cnt_q : cnt_q - 3'd1;
        end
    end

    assign cap_idx = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        sgn_d    = sgn_q;
        buffer_d = buffer_q;
        addr_d   = addr_q;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_d    = mis_q;
`endif
        ram_a    = '0;
        ram_wr   = 1'b0;
        ram_dout = '0;

        case (state_q)
            MA_IDLE: begin
                if (mem_save || mem_load) begin
                    addr_d   = mem_addr[ADDR_W-1:0];
                    len_d    = norm_len(mem_len);
                    sgn_d    = mem_signed;
                    cnt_d    = '0;
                    kind_d   = mem_save ? ACC_ST : ACC_LD;
                    buffer_d = mem_save ? mem_wdata : '0;
                    state_d  = mem_save ? MA_ST_WR : MA_LD_RD;
`ifdef MEM_MISALIGN_TRAP_EN
                    mis_d    = 1'b0;
                    if (is_misaligned(norm_len(mem_len), mem_addr[1:0])) begin
                        mis_d    = 1'b1;
                        buffer_d = '0;
                        state_d  = MA_DONE;
                    end
`endif
                end else if (if_req && !if_flush) begin
                    addr_d   = if_addr[ADDR_W-1:0];
                    len_d    = MA_LEN_W;
                    sgn_d    = 1'b0;
                    cnt_d    = '0;
                    kind_d   = ACC_IF;
                    buffer_d = '0;
                    state_d  = MA_IF_RD;
`ifdef MEM_MISALIGN_TRAP_EN
                    mis_d    = 1'b0;
`endif
                end
            end
            MA_IF_RD, MA_LD_RD: begin
                ram_a = addr_q + ADDR_W'(rd_off);
                if (cnt_q != 3'd0) begin
                    buffer_d[{cap_idx, 3'b000} +: 8] = ram_din;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == len_q) begin
                    state_d = MA_DONE;
                end
                if ((state_q == MA_IF_RD) && if_flush) begin
                    state_d = MA_IDLE;
                end
            end
            MA_ST_WR: begin
                ram_a    = addr_q + ADDR_W'(cnt_q);
                ram_dout = buffer_q[{cnt_q[1:0], 3'b000} +: 8];
                ram_wr   = rdy;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == len_q - 3'd1) begin
                    state_d = MA_DONE;
                end
            end
            MA_DONE: begin
                state_d = MA_IDLE;
            end
            default: begin
                state_d = MA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= MA_IDLE;
            kind_q   <= ACC_IF;
            cnt_q    <= '0;
            len_q    <= MA_LEN_W;
            sgn_q    <= 1'b0;
            buffer_q <= '0;
            addr_q   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else if (rdy) begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            sgn_q    <= sgn_d;
            buffer_q <= buffer_d;
            addr_q   <= addr_d;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q    <= mis_d;
`endif
        end
    end

    assign if_done   = (state_q == MA_DONE) && (kind_q == ACC_IF);
    assign if_inst   = if_done ? buffer_q : '0;
    assign mem_done  = (state_q == MA_DONE) && (kind_q != ACC_IF);
    assign mem_rdata = (mem_done && (kind_q == ACC_LD)) ? packed_word : '0;
`ifdef MEM_MISALIGN_TRAP_EN
    assign mem_misalign = mem_done && mis_q;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the byte-wide single-port synchronous RAM.
- Arbitrates between instruction fetch (IF, 4-byte reads) and the MEM stage (load/store of 1/2/4 bytes, driven by EX's load/save/sl_reg_address/sl_data/sl_data_length/sl_data_signed).
- Serialises every access into little-endian byte cycles and returns assembled, sign-/zero-extended words.
- Data requests win over fetch; a branch flush can abort a fetch in progress.

Parameters:
- ADDR_W, 17, RAM byte-address width; request addresses are truncated to ADDR_W bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- rdy  in  1  global enable; low = freeze
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch address
- if_flush  in  1  branch misprediction; abort fetch
- if_done  out  1  one-cycle pulse, if_inst valid
- if_inst  out  32  fetched word
- mem_load  in  1  load request, held until mem_done
- mem_save  in  1  store request, held until mem_done
- mem_addr  in  32  data address
- mem_wdata  in  32  store data; low bytes used
- mem_len  in  3  1, 2 or 4 bytes
- mem_signed  in  1  load sign-extend
- mem_done  out  1  one-cycle pulse, access complete
- mem_rdata  out  32  extended load data; 0 for stores
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid one cycle after its address

Behaviour:
- Reset (rst=0 at edge): state IDLE, cnt=0, buffer=0, if_done=0, mem_done=0, if_inst=0, mem_rdata=0, ram_wr=0, ram_a=0, ram_dout=0.
- States: IDLE, IF_RD, LD_RD, ST_WR, DONE.
- IDLE priority: mem_save / mem_load > if_req. mem_load and mem_save are never both high; if they are, save wins.
- On acceptance, latch addr, len and signed, and go to the access state.
- Accesses are never pre-empted by a later data request.
- Read states (IF_RD, LD_RD):
  - Cycle k (k=0..len-1) drives ram_a = (addr+k) mod 2^ADDR_W.
  - Byte k is captured into buffer[8k+7:8k] in cycle k+1.
  - After the last capture, go to DONE.
  - IF len is fixed at 4.
- Load result:
  - len 1: bits [31:8] = signed ? bit 7 : 0.
  - len 2: bits [31:16] = signed ? bit 15 : 0.
  - len 4: unmodified.
- ST_WR: cycle k drives ram_a=addr+k, ram_dout=wdata[8k+7:8k], ram_wr=1; after len cycles go to DONE.
- DONE: exactly one cycle with the matching done pulse and data; then IDLE. Requests are ignored in DONE, so a request still held is not re-accepted.
- Latency, request sampled at edge E0:
  - LW / fetch: done high in the cycle after edge E0+5.
  - LB: done after E0+2.
  - SW: done after E0+4; SB: done after E0+1.
- if_flush:
  - In IF_RD: abort, go to IDLE next edge, no if_done.
  - In IDLE or any data state: no effect on the data access; a pending if_req is not accepted that cycle.
- rdy=0: all registers hold and ram_wr is forced 0. A read byte whose data would land in a frozen cycle is re-issued on resume. The result is identical to the same access with rdy always high, stretched.
- Address wrap: addr+k above 2^ADDR_W-1 wraps to 0.
- Reset mid-access: abort immediately, no done pulse, no further ram_wr.
- Illegal mem_len (0, 3, ≥5): treated as 4.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - Adds output mem_misalign (1 bit).
  - A data access with len 2 and addr[0]≠0, or len 4 and addr[1:0]≠0, performs no RAM cycle.
  - It goes straight to DONE: mem_done=1, mem_misalign=1, mem_rdata=0.
  - mem_misalign is 0 at reset and whenever mem_done=0.
- Undefined: misaligned accesses are performed byte-serially like aligned ones, and the port does not exist.

Decomposition:
- defines.v gains:
  - state encodings MA_IDLE/MA_IF_RD/MA_LD_RD/MA_ST_WR/MA_DONE;
  - length codes MA_LEN_B=1, MA_LEN_H=2, MA_LEN_W=4;
  - RAM_ADDR_W=17.
- One sub-module, mem_byte_packer (combinational): buffer + len + signed → extended 32-bit word.
- Both mem_arbiter and the bench use mem_byte_packer.

Test Plan:
- Fetch only: RAM[0x100..0x103]=13,05,10,00; if_req, if_addr=0x100 → if_inst=0x00100513, if_done one cycle after E0+5; ram_wr never 1.
- Priority: if_req and mem_save together, SW 0xDEADBEEF to 0x200 → RAM[0x200..0x203]=EF,BE,AD,DE written first; fetch then completes correctly.
- Signed loads: RAM[0x40]=0x80 → LB gives 0xFFFFFF80, LBU gives 0x00000080; RAM[0x40..0x41]=0x34,0x92 → LH gives 0xFFFF9234.
- Flush: if_flush asserted in cycle 2 of a fetch → no if_done; a mem_load issued next cycle completes with correct data.
- rdy stall: LW from 0x1FFFE (wraps to 0x00000) with rdy low for 3 cycles mid-access → correct word; ram_wr stays 0; done 3 cycles later than the unstalled run.
- Reset mid-SW after 2 bytes → only 2 bytes written, no mem_done, outputs 0. With MEM_MISALIGN_TRAP_EN, LW at 0x2 → mem_misalign=1, no RAM access.
